// File: rtl/s3g_host_master_pkg.sv
// Shared constants, error codes and the CRC8 byte update for the S3G host master.
// Dallas/Maxim CRC8: reflected poly 0x31 (0x8C), init 0x00, payload bytes only.
package s3g_host_master_pkg;

  localparam logic [7:0] S3G_START       = 8'hD5;
  localparam logic [7:0] CRC_POLY        = 8'h8C;
  localparam int         MAX_PAYLOAD_DEF = 16;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_CRC     = 2'd2,
    ERR_LEN     = 2'd3
  } err_e;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    // NOTE: blocking '=' inside functions and always_comb is intended; each loop step
    // must see the previous step's value.
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_host_master_crc8.sv
// Combinational byte-wide CRC8 update; one instance each on the TX and RX paths.
module s3g_host_master_crc8
  import s3g_host_master_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_update(crc_in, data);

endmodule

// File: rtl/s3g_host_master.sv
// S3G host initiator: frames one command (D5, len, payload, CRC8) to a UART TX, then
// receives and validates the reply from a UART RX, retrying on timeout or a bad frame.
module s3g_host_master
  import s3g_host_master_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF,
  parameter int TIMEOUT     = 100000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_wr,
  input  logic [7:0]               cmd_len,
  input  logic [8*MAX_PAYLOAD-1:0] cmd_buf,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  input  logic                     tx_done,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     resp_valid,
  output logic                     resp_error,
  output logic [1:0]               err_code,
  output logic [7:0]               resp_len,
  output logic [8*MAX_PAYLOAD-1:0] resp_buf
);

  localparam int BW = 8 * MAX_PAYLOAD;
  localparam int PW = $clog2(MAX_PAYLOAD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0]    MAX_LEN8    = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT);
  localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TX_BYTE, ST_TX_WAIT, ST_RX_START, ST_RX_LEN, ST_RX_PAY, ST_RX_CRC
  } state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [4:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_crc_q, tx_crc_d;
  logic [4:0]    len_q, len_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    rx_len_q, rx_len_d;
  logic [4:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_crc_q, rx_crc_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_error_q, resp_error_d;
  err_e          err_code_q, err_code_d;
  logic [7:0]    resp_len_q, resp_len_d;
  logic [BW-1:0] resp_buf_q, resp_buf_d;
  logic [BW-1:0] cmd_buf_q, cmd_buf_d;

  logic [7:0]    tx_crc_out, rx_crc_out, tx_crc_upd, tx_next_byte;
  logic [4:0]    tx_nxt, pay_sel;
  logic [TW-1:0] tmo_inc;
  logic          tx_is_pay, rx_active, fail, start_frame;
  err_e          fail_code;

  s3g_host_master_crc8 u_tx_crc (.crc_in(tx_crc_q), .data(tx_data_q), .crc_out(tx_crc_out));
  s3g_host_master_crc8 u_rx_crc (.crc_in(rx_crc_q), .data(rx_data),   .crc_out(rx_crc_out));

  // Frame byte index: 0 = start, 1 = length, 2..len+1 = payload, len+2 = CRC.
  assign tx_nxt       = tx_idx_q + 5'd1;
  assign pay_sel      = tx_nxt - 5'd2;
  assign tx_is_pay    = (tx_idx_q >= 5'd2) && (tx_idx_q <= len_q + 5'd1);
  assign tx_crc_upd   = tx_is_pay ? tx_crc_out : tx_crc_q;
  assign tx_next_byte = (tx_nxt == 5'd1)          ? {3'b000, len_q} :
                        (tx_nxt <= len_q + 5'd1)  ? cmd_buf_q[{pay_sel[PW-1:0], 3'b000} +: 8] :
                                                    tx_crc_upd;
  assign rx_active    = (state_q == ST_RX_START) || (state_q == ST_RX_LEN) ||
                        (state_q == ST_RX_PAY)   || (state_q == ST_RX_CRC);
  assign tmo_inc      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    busy_d       = busy_q;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data_q;
    tx_idx_d     = tx_idx_q;
    tx_crc_d     = tx_crc_q;
    len_d        = len_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    rx_len_d     = rx_len_q;
    rx_idx_d     = rx_idx_q;
    rx_crc_d     = rx_crc_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    err_code_d   = err_code_q;
    resp_len_d   = resp_len_q;
    resp_buf_d   = resp_buf_q;
    cmd_buf_d    = cmd_buf_q;
    fail         = 1'b0;
    fail_code    = ERR_NONE;
    start_frame  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_wr) begin
          if (cmd_len == 8'd0 || cmd_len > MAX_LEN8) begin
            resp_error_d = 1'b1;
            err_code_d   = ERR_LEN;
          end else begin
            cmd_buf_d   = cmd_buf;
            len_d       = cmd_len[4:0];
            resp_len_d  = '0;
            resp_buf_d  = '0;
            err_code_d  = ERR_NONE;
            retry_d     = '0;
            start_frame = 1'b1;
          end
        end
      end
      ST_TX_BYTE: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (tx_done) begin
          tx_crc_d = tx_crc_upd;
          if (tx_idx_q == len_q + 5'd2) begin
            state_d  = ST_RX_START;
            tmo_d    = '0;
            rx_idx_d = '0;
            rx_crc_d = '0;
          end else begin
            state_d   = ST_TX_BYTE;
            tx_idx_d  = tx_nxt;
            tx_data_d = tx_next_byte;
            tx_wr_d   = 1'b1;
          end
        end
      end
      ST_RX_START: begin
        if (rx_done && rx_data == S3G_START) state_d = ST_RX_LEN;
      end
      ST_RX_LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN8) begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
          end else begin
            rx_len_d = rx_data[4:0];
            rx_idx_d = '0;
            rx_crc_d = '0;
            state_d  = ST_RX_PAY;
          end
        end
      end
      ST_RX_PAY: begin
        if (rx_done) begin
          resp_buf_d[{rx_idx_q[PW-1:0], 3'b000} +: 8] = rx_data;
          rx_crc_d = rx_crc_out;
          rx_idx_d = rx_idx_q + 5'd1;
          if (rx_idx_q == rx_len_q - 5'd1) state_d = ST_RX_CRC;
        end
      end
      ST_RX_CRC: begin
        if (rx_done) begin
          if (rx_data == rx_crc_q) begin
            resp_valid_d = 1'b1;
            resp_len_d   = {3'b000, rx_len_q};
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CRC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A received byte always takes priority over an expiring timeout.
    if (rx_active) begin
      if (rx_done) begin
        tmo_d = '0;
      end else if (tmo_inc == TMO_MAX) begin
        fail      = 1'b1;
        fail_code = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_inc;
      end
    end

    if (fail) begin
      if (retry_q < MAX_RETRY_W) begin
        retry_d     = retry_q + 1'b1;
        resp_buf_d  = '0;
        start_frame = 1'b1;
      end else begin
        resp_error_d = 1'b1;
        err_code_d   = fail_code;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
    end

    if (start_frame) begin
      state_d   = ST_TX_BYTE;
      busy_d    = 1'b1;
      tx_wr_d   = 1'b1;
      tx_data_d = S3G_START;
      tx_idx_d  = '0;
      tx_crc_d  = '0;
      tmo_d     = '0;
    end
  end

  // NOTE: state flops use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      tx_wr_q      <= 1'b0;
      tx_data_q    <= '0;
      tx_idx_q     <= '0;
      tx_crc_q     <= '0;
      len_q        <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      rx_len_q     <= '0;
      rx_idx_q     <= '0;
      rx_crc_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      err_code_q   <= ERR_NONE;
      resp_len_q   <= '0;
      resp_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      tx_wr_q      <= tx_wr_d;
      tx_data_q    <= tx_data_d;
      tx_idx_q     <= tx_idx_d;
      tx_crc_q     <= tx_crc_d;
      len_q        <= len_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      rx_len_q     <= rx_len_d;
      rx_idx_q     <= rx_idx_d;
      rx_crc_q     <= rx_crc_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      err_code_q   <= err_code_d;
      resp_len_q   <= resp_len_d;
      resp_buf_q   <= resp_buf_d;
    end
  end

  // NOTE: the latched command is pure datapath, only read after a fresh load, so it
  // carries no reset and stays out of the reset fan-out.
  always_ff @(posedge clk) begin
    cmd_buf_q <= cmd_buf_d;
  end

  assign busy       = busy_q;
  assign tx_wr      = tx_wr_q;
  assign tx_data    = tx_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign err_code   = err_code_q;
  assign resp_len   = resp_len_q;
  assign resp_buf   = resp_buf_q;

endmodule

// File: tb/tb_s3g_host_master.sv
// Self-checking bench for s3g_host_master: UART TX/RX models, TX byte and response
// scoreboards, a table of good transactions and hand-written retry/error/reset sequences.
module tb_s3g_host_master;
  import s3g_host_master_pkg::*;

  localparam int MAXP = 16;
  localparam int TMO  = 200;
  localparam int MAXR = 2;

  logic         clk = 1'b0;
  logic         rst, cmd_wr, busy, tx_wr, tx_done, rx_done, resp_valid, resp_error;
  logic [7:0]   cmd_len, tx_data, rx_data, resp_len;
  logic [127:0] cmd_buf, resp_buf;
  logic [1:0]   err_code;

  s3g_host_master #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_len(cmd_len), .cmd_buf(cmd_buf),
    .busy(busy), .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done), .resp_valid(resp_valid),
    .resp_error(resp_error), .err_code(err_code), .resp_len(resp_len), .resp_buf(resp_buf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_err;
    logic [1:0]   err;
    logic [7:0]   len;
    logic [127:0] data;
  } resp_t;

  typedef struct {
    int           clen;
    logic [127:0] cdata;
    int           rlen;
    logic [127:0] rdata;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         tx_cnt  = 0;
  int         frames  = 0;
  int         resp_cyc = 0;
  logic [7:0] exp_tx[$];
  resp_t      exp_resp[$];
  logic [7:0] rx_q[$];
  vec_t       vt[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Bit-serial Dallas CRC8 reference (LSB first, feedback 0x8C).
  function automatic logic [7:0] crc_of(input int len, input logic [127:0] d);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[8*i+b];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  function automatic logic [127:0] mask(input int len, input logic [127:0] d);
    return d & ((128'd1 << (8*len)) - 128'd1);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART TX model: scoreboards each tx_wr byte, answers with tx_done ~5 cycles later.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) tx_cnt = 0;
      else begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (tx_wr) begin
          if (tx_data == 8'hD5) frames++;
          if (exp_tx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %0h, expected no TX", tx_data);
          end else check("tx_byte", 128'(tx_data), 128'(exp_tx.pop_front()));
          tx_cnt = 4;
        end
      end
    end
  end

  // Response monitor.
  initial forever begin
    resp_t e;
    @(negedge clk);
    if (resp_valid || resp_error) begin
      resp_cyc = cyc;
      check("resp_excl", 128'(resp_valid & resp_error), 128'(0));
      check("resp_busy", 128'(busy), 128'(0));
      if (exp_resp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got valid=%0b error=%0b, expected none", resp_valid, resp_error);
      end else begin
        e = exp_resp.pop_front();
        check("resp_kind", 128'(resp_error), 128'(e.is_err));
        if (e.is_err) check("err_code", 128'(err_code), 128'(e.err));
        else begin
          check("resp_len", 128'(resp_len), 128'(e.len));
          check("resp_buf", resp_buf, e.data);
        end
      end
    end
  end

  task automatic push_frame(input int len, input logic [127:0] d);
    exp_tx.push_back(8'hD5);
    exp_tx.push_back(8'(len));
    for (int i = 0; i < len; i++) exp_tx.push_back(d[8*i +: 8]);
    exp_tx.push_back(crc_of(len, d));
  endtask

  task automatic push_ok(input int len, input logic [127:0] d);
    resp_t r;
    r.is_err = 1'b0; r.err = 2'd0; r.len = 8'(len); r.data = mask(len, d);
    exp_resp.push_back(r);
  endtask

  task automatic push_err(input logic [1:0] code);
    resp_t r;
    r.is_err = 1'b1; r.err = code; r.len = 8'd0; r.data = '0;
    exp_resp.push_back(r);
  endtask

  task automatic issue(input int len, input logic [127:0] d);
    @(negedge clk);
    cmd_len = 8'(len);
    cmd_buf = d;
    cmd_wr  = 1'b1;
    @(negedge clk);
    cmd_wr  = 1'b0;
  endtask

  // Wait until only 'remain' expected TX bytes are left and the UART is idle.
  task automatic wait_tx(input int remain);
    int k = 0;
    while ((exp_tx.size() > remain || tx_cnt != 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      flag("wait_tx timeout");
      exp_tx.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_resp(input int bound);
    int k = 0;
    while (exp_resp.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (k >= bound) begin
      flag("wait_resp timeout");
      exp_resp.delete();
    end
    @(negedge clk);
  endtask

  task automatic send_rx();
    while (rx_q.size() != 0) begin
      @(negedge clk);
      rx_data = rx_q.pop_front();
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic reply(input int len, input logic [127:0] d, input logic [7:0] crc);
    rx_q.push_back(8'hD5);
    rx_q.push_back(8'(len));
    for (int i = 0; i < len; i++) rx_q.push_back(d[8*i +: 8]);
    rx_q.push_back(crc);
    send_rx();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f0;
    rst = 1'b1; cmd_wr = 1'b0; cmd_len = '0; cmd_buf = '0; rx_data = '0; rx_done = 1'b0;

    vt[0] = '{3,  128'h030201, 3, 128'h030201};
    vt[1] = '{1,  128'hA5, 1, 128'h5A};
    vt[2] = '{16, 128'h0F0E0D0C0B0A09080706050403020100, 16, 128'hFFEEDDCCBBAA99887766554433221100};
    vt[3] = '{7,  mask(7, {$urandom, $urandom, $urandom, $urandom}), 11,
              mask(11, {$urandom, $urandom, $urandom, $urandom})};
    vt[4] = '{MAXP - 1, mask(MAXP - 1, {$urandom, $urandom, $urandom, $urandom}), 2, 128'hBEEF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",     128'(busy),       128'(0));
    check("rst_tx_wr",    128'(tx_wr),      128'(0));
    check("rst_valid",    128'(resp_valid), 128'(0));
    check("rst_error",    128'(resp_error), 128'(0));
    check("rst_err_code", 128'(err_code),   128'(0));
    check("rst_resp_len", 128'(resp_len),   128'(0));
    check("rst_resp_buf", resp_buf,         128'(0));

    // Table of single-attempt good transactions (includes D5 03 01 02 03 D8).
    for (int i = 0; i < 5; i++) begin
      push_frame(vt[i].clen, vt[i].cdata);
      push_ok(vt[i].rlen, vt[i].rdata);
      issue(vt[i].clen, vt[i].cdata);
      check("busy_after_cmd", 128'(busy), 128'(1));
      wait_tx(0);
      reply(vt[i].rlen, vt[i].rdata, crc_of(vt[i].rlen, vt[i].rdata));
      wait_resp(1000);
    end

    // Bad CRC reply forces a full resend, then a good reply completes.
    push_frame(3, 128'h030201);
    push_frame(3, 128'h030201);
    push_ok(3, 128'h030201);
    issue(3, 128'h030201);
    check("cmd_clears_len", 128'(resp_len), 128'(0));
    check("cmd_clears_buf", resp_buf, 128'(0));
    wait_tx(6);
    reply(3, 128'h030201, 8'hCC);
    wait_tx(0);
    reply(3, 128'h030201, 8'hD8);
    wait_resp(1000);

    // No reply at all: three frames, then a timeout error.
    f0 = frames;
    push_frame(3, 128'h030201);
    push_frame(3, 128'h030201);
    push_frame(3, 128'h030201);
    push_err(2'd1);
    t0 = cyc;
    issue(3, 128'h030201);
    wait_resp(3000);
    check("t3_frames", 128'(frames - f0), 128'(3));
    check("t3_time_lo", 128'(resp_cyc - t0 >= 3*TMO + 90), 128'(1));
    check("t3_time_hi", 128'(resp_cyc - t0 <= 3*TMO + 160), 128'(1));

    // Junk byte ahead of the start byte is dropped.
    push_frame(3, 128'h030201);
    push_ok(3, 128'h020100);
    issue(3, 128'h030201);
    wait_tx(0);
    rx_q.push_back(8'h0D);
    send_rx();
    reply(3, 128'h020100, 8'h78);
    wait_resp(1000);

    // Reply length 27 on every attempt: length error after the last retry.
    push_frame(2, 128'h2211);
    push_frame(2, 128'h2211);
    push_frame(2, 128'h2211);
    push_err(2'd3);
    issue(2, 128'h2211);
    for (int k = 0; k < 3; k++) begin
      wait_tx(10 - 5*k);
      rx_q.push_back(8'hD5);
      rx_q.push_back(8'h1B);
      send_rx();
    end
    wait_resp(1000);

    // Illegal command lengths: immediate error, nothing transmitted.
    push_err(2'd3);
    issue(0, 128'h55);
    wait_resp(20);
    push_err(2'd3);
    issue(MAXP + 1, 128'h55);
    wait_resp(20);
    repeat (5) @(negedge clk);
    check("err_code_hold", 128'(err_code), 128'(3));
    check("idle_busy",     128'(busy),     128'(0));

    // Reset in the middle of the payload.
    push_frame(8, 128'h8877665544332211);
    issue(8, 128'h8877665544332211);
    begin
      int k = 0;
      while (exp_tx.size() > 6 && k < 500) begin
        @(posedge clk);
        k++;
      end
      if (k >= 500) flag("rst_wait timeout");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    check("midrst_tx_wr", 128'(tx_wr), 128'(0));
    check("midrst_busy",  128'(busy),  128'(0));
    check("midrst_valid", 128'(resp_valid | resp_error), 128'(0));
    repeat (10) @(negedge clk);

    // A second cmd_wr while busy is ignored; the first frame goes out unchanged.
    push_frame(4, 128'h44332211);
    push_ok(2, 128'hCAFE);
    issue(4, 128'h44332211);
    repeat (3) @(negedge clk);
    issue(5, 128'h9999999999);
    wait_tx(0);
    reply(2, 128'hCAFE, crc_of(2, 128'hCAFE));
    wait_resp(1000);
    repeat (5) @(negedge clk);
    check("buf_held", resp_buf, 128'hCAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
